result_monitor: RTL and testbench

- Receiving end of the operand stream produced by the testbench driver.
- Keeps a history of the operands the driver presented to the DUT and latches the DUT latency once the driver reports it.
- Checks every subsequent DUT result against a golden model, keeping saturating pass/fail counts and capturing the first mismatch.
- Sits between the driver/DUT pair and the result display/readout logic, all on the DUT clock.

---
 rtl/result_monitor.sv | 120 ++++++++++++
 tb/tb_result_monitor.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/result_monitor.sv
// result_monitor: checks DUT results against a golden model using a history of driven operands
module result_monitor #(
    parameter int              WIDTH      = 32,
    parameter int              DEPTH      = 16,
    parameter int              OP         = 0,
    parameter longint unsigned NUM_CHECKS = 1000
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_drive_a,
    input  logic [WIDTH-1:0] i_drive_b,
    input  logic [WIDTH-1:0] i_dut_out,
    input  logic [31:0]      i_dut_delay,
    input  logic             i_run,
    output logic [2:0]       o_state,
    output logic [31:0]      o_pass_count,
    output logic [31:0]      o_fail_count,
    output logic [WIDTH-1:0] o_first_a,
    output logic [WIDTH-1:0] o_first_b,
    output logic [WIDTH-1:0] o_first_got,
    output logic [WIDTH-1:0] o_first_exp,
    output logic             o_done,
    output logic             o_error
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] hist_a [DEPTH];
    logic [WIDTH-1:0] hist_b [DEPTH];
    logic [DEPTH-1:0] hist_v;
    logic [31:0]      lat;
    logic [63:0]      total;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] smp_a, smp_b, exp_val;
    logic             smp_v, counted, match, lat_ok;

    // Entry L-1 of the history holds the operands whose result is on i_dut_out now
    assign idx     = IW'(lat - 32'd1);
    assign smp_a   = hist_a[idx];
    assign smp_b   = hist_b[idx];
    assign smp_v   = hist_v[idx];
    assign exp_val = (OP == 1) ? smp_a - smp_b : (OP == 2) ? smp_a * smp_b : smp_a + smp_b;
    assign match   = i_dut_out == exp_val;
    assign counted = state == CHECK && i_run && smp_v && total < NUM_CHECKS;
    assign lat_ok  = i_dut_delay >= 32'd1 && i_dut_delay <= 32'(DEPTH);
    assign o_state = state;
    assign o_done  = state == DONE;
    assign o_error = state == FAULT;

    // State register
    always_ff @(posedge clk_dut) begin
        state <= reset ? IDLE : state_nxt;
    end

    // Next state: wait for a measured latency, validate it once, then check until the quota is met
    always_comb begin
        state_nxt = state;
        if (state == IDLE && i_dut_delay != 32'hFFFF) state_nxt = LOAD;
        if (state == LOAD) state_nxt = lat_ok ? CHECK : FAULT;
        if (counted && total + 64'd1 == NUM_CHECKS) state_nxt = DONE;
    end

    // Operand history shifts every cycle; the valid bits mark entries filled since reset
    always_ff @(posedge clk_dut) begin
        if (reset) begin
            hist_v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                hist_a[k] <= '0;
                hist_b[k] <= '0;
            end
        end else begin
            hist_v    <= (hist_v << 1) | DEPTH'(1);
            hist_a[0] <= i_drive_a;
            hist_b[0] <= i_drive_b;
            for (int k = 1; k < DEPTH; k++) begin
                hist_a[k] <= hist_a[k-1];
                hist_b[k] <= hist_b[k-1];
            end
        end
    end

    // Latency is captured only in LOAD, so later changes on i_dut_delay are ignored
    always_ff @(posedge clk_dut) begin
        if (reset) lat <= '0;
        else if (state == LOAD) lat <= i_dut_delay;
    end

    // Saturating pass/fail counters and first-mismatch capture
    always_ff @(posedge clk_dut) begin
        if (reset) begin
            total        <= '0;
            o_pass_count <= '0;
            o_fail_count <= '0;
            o_first_a    <= '0;
            o_first_b    <= '0;
            o_first_got  <= '0;
            o_first_exp  <= '0;
        end else if (counted) begin
            total <= total + 64'd1;
            if (match) o_pass_count <= o_pass_count + {31'd0, o_pass_count != '1};
            else begin
                o_fail_count <= o_fail_count + {31'd0, o_fail_count != '1};
                if (o_fail_count == '0) begin
                    o_first_a   <= smp_a;
                    o_first_b   <= smp_b;
                    o_first_got <= i_dut_out;
                    o_first_exp <= exp_val;
                end
            end
        end
    end
endmodule

// File: tb/tb_result_monitor.sv
// tb_result_monitor: scoreboard bench driving operands and a modelled DUT into result_monitor
module tb_result_monitor;
    localparam int NC = 100;

    typedef struct {
        logic        f;
        logic [31:0] a, b, got, exp;
    } item_t;

    logic        clk_dut = 0;
    logic        reset = 1;
    logic [31:0] drive_a = 0, drive_b = 0, dut_delay = 32'hFFFF, corrupt = 0;
    logic        run = 0, sel = 0;
    int          lat = 1;
    logic [31:0] qa [20];
    logic [31:0] qb [20];
    logic [31:0] pa, pb, out_add, out_mul;

    logic [2:0]  a_state, m_state, s_state;
    logic [31:0] a_pass, a_fail, a_fa, a_fb, a_fg, a_fe;
    logic [31:0] m_pass, m_fail, m_fa, m_fb, m_fg, m_fe;
    logic [31:0] s_pass, s_fail, s_fa, s_fb, s_fg, s_fe;
    logic        a_done, a_err, m_done, m_err, s_done, s_err;

    int          checks = 0, errors = 0, issued = 0;
    bit          held = 0, hold_pending = 0, ff_set = 0;
    logic [127:0] ff;
    item_t       sbq [$];
    logic [31:0] da [256];
    logic [31:0] db [256];

    logic [31:0] mt_a [8] = '{32'h0001_0000, 32'hFFFF_FFFF, 32'h0, 32'h3, 32'h1234_5678, 32'h8000_0000, 32'h0000_FFFF, 32'hDEAD_BEEF};
    logic [31:0] mt_b [8] = '{32'h0001_0000, 32'h2, 32'h0, 32'h5, 32'h10, 32'h3, 32'h0000_FFFF, 32'h1};
    logic [31:0] mt_e [8] = '{32'h0, 32'hFFFF_FFFE, 32'h0, 32'hF, 32'h2345_6780, 32'h8000_0000, 32'hFFFE_0001, 32'hDEAD_BEEF};

    always #5 clk_dut = ~clk_dut;

    // Modelled DUT: result of the operands driven lat cycles ago, optionally corrupted
    always @(posedge clk_dut) begin
        qa[0] <= drive_a;
        qb[0] <= drive_b;
        for (int i = 1; i < 20; i++) begin
            qa[i] <= qa[i-1];
            qb[i] <= qb[i-1];
        end
    end
    assign pa      = qa[(lat < 1) ? 0 : lat - 1];
    assign pb      = qb[(lat < 1) ? 0 : lat - 1];
    assign out_add = (pa + pb) ^ corrupt;
    assign out_mul = (pa * pb) ^ corrupt;

    result_monitor #(.WIDTH(32), .DEPTH(16), .OP(0), .NUM_CHECKS(NC)) u_add (
        .clk_dut(clk_dut), .reset(reset), .i_drive_a(drive_a), .i_drive_b(drive_b),
        .i_dut_out(out_add), .i_dut_delay(dut_delay), .i_run(run), .o_state(a_state),
        .o_pass_count(a_pass), .o_fail_count(a_fail), .o_first_a(a_fa), .o_first_b(a_fb),
        .o_first_got(a_fg), .o_first_exp(a_fe), .o_done(a_done), .o_error(a_err));

    result_monitor #(.WIDTH(32), .DEPTH(16), .OP(2), .NUM_CHECKS(NC)) u_mul (
        .clk_dut(clk_dut), .reset(reset), .i_drive_a(drive_a), .i_drive_b(drive_b),
        .i_dut_out(out_mul), .i_dut_delay(dut_delay), .i_run(run), .o_state(m_state),
        .o_pass_count(m_pass), .o_fail_count(m_fail), .o_first_a(m_fa), .o_first_b(m_fb),
        .o_first_got(m_fg), .o_first_exp(m_fe), .o_done(m_done), .o_error(m_err));

    always_comb begin
        s_state = sel ? m_state : a_state;
        s_pass  = sel ? m_pass  : a_pass;
        s_fail  = sel ? m_fail  : a_fail;
        s_fa    = sel ? m_fa    : a_fa;
        s_fb    = sel ? m_fb    : a_fb;
        s_fg    = sel ? m_fg    : a_fg;
        s_fe    = sel ? m_fe    : a_fe;
        s_done  = sel ? m_done  : a_done;
        s_err   = sel ? m_err   : a_err;
    end

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Monitor: every change of the counters pops one expected compare from the scoreboard
    initial begin
        logic [31:0] prev_p, prev_f;
        bit          first_seen;
        item_t       it;
        prev_p = 0;
        prev_f = 0;
        first_seen = 0;
        forever begin
            @(posedge clk_dut);
            #1;
            if (reset) begin
                chk("reset_outputs", {s_state, s_pass, s_fail, s_done, s_err, s_fa, s_fb, s_fg, s_fe}, '0);
                prev_p = 0;
                prev_f = 0;
                first_seen = 0;
            end else if (s_pass != prev_p || s_fail != prev_f) begin
                if (sbq.size() == 0) chk("unexpected_count", {s_pass, s_fail}, {prev_p, prev_f});
                else begin
                    it = sbq.pop_front();
                    chk("count_step", {s_pass, s_fail}, it.f ? {prev_p, prev_f + 32'd1} : {prev_p + 32'd1, prev_f});
                    if (it.f && !first_seen) begin
                        first_seen = 1;
                        chk("first_fail", {s_fa, s_fb, s_fg, s_fe}, {it.a, it.b, it.got, it.exp});
                    end
                end
                prev_p = s_pass;
                prev_f = s_fail;
            end
        end
    end

    task automatic do_reset();
        chk("sb_drained", sbq.size(), 0);
        @(negedge clk_dut);
        reset = 1;
        dut_delay = 32'hFFFF;
        run = 0;
        corrupt = 0;
        @(negedge clk_dut);
        reset = 0;
        issued = 0;
        held = 0;
        ff_set = 0;
    endtask

    // Drives n cycles: wu cycles of unmeasured latency, then L; pushes every compare it expects
    task automatic run_seq(input int mode, input int L, input int wu, input int n, input bit gaps, input bit corr);
        logic [31:0] e;
        item_t it;
        lat = L;
        for (int j = 0; j < n; j++) begin
            @(negedge clk_dut);
            if (hold_pending) begin
                chk("hold_in_check", s_state, 2);
                hold_pending = 0;
            end
            dut_delay = (j < wu) ? 32'hFFFF : 32'(L);
            da[j] = (mode == 0) ? 32'(j) * 32'h9E37_79B9 + 32'h1234 : mt_a[j % 8];
            db[j] = (mode == 0) ? ~(32'(j) * 32'h0100_0193) : mt_b[j % 8];
            drive_a = da[j];
            drive_b = db[j];
            run = 1;
            if (gaps && j % 13 == 5) run = 0;
            if (mode == 1 && j >= 7 && j < 10) run = 0;
            if (gaps && issued == NC - 1 && !held && j >= wu + 2) begin
                run = 0;
                held = 1;
                hold_pending = 1;
            end
            corrupt = 0;
            if (j >= wu + 2 && run && issued < NC) begin
                issued++;
                e = (mode == 0) ? da[j-L] + db[j-L] : mt_e[(j-L) % 8];
                corrupt = (corr && (issued == 10 || issued == 20)) ? 32'h1 : 32'h0;
                it = '{corrupt != 0, da[j-L], db[j-L], e ^ corrupt, e};
                sbq.push_back(it);
                if (corrupt != 0 && !ff_set) begin
                    ff_set = 1;
                    ff = {it.a, it.b, it.got, it.exp};
                end
            end
        end
        @(negedge clk_dut);
        run = 0;
        corrupt = 0;
    endtask

    task automatic fault_test(input logic [31:0] d);
        do_reset();
        @(negedge clk_dut);
        dut_delay = d;
        run = 1;
        @(negedge clk_dut);
        chk("fault_load_state", s_state, 1);
        @(negedge clk_dut);
        chk("fault_state", {s_state, s_err, s_done}, {3'd4, 1'b1, 1'b0});
        dut_delay = 32'd3;
        repeat (5) @(negedge clk_dut);
        chk("fault_sticky", {s_state, s_pass, s_fail}, {3'd4, 32'd0, 32'd0});
    endtask

    initial begin
        do_reset();
        repeat (50) @(negedge clk_dut);
        chk("idle_state", s_state, 0);
        chk("idle_counts", {s_pass, s_fail}, 0);
        chk("idle_flags", {s_done, s_err}, 0);

        do_reset();
        run_seq(0, 3, 5, 130, 1, 0);
        chk("add_pass", s_pass, 100);
        chk("add_fail", s_fail, 0);
        chk("add_done", {s_state, s_done, s_err}, {3'd3, 1'b1, 1'b0});

        do_reset();
        run_seq(0, 3, 5, 120, 0, 1);
        chk("corr_pass", s_pass, 98);
        chk("corr_fail", s_fail, 2);
        chk("corr_first", {s_fa, s_fb, s_fg, s_fe}, ff);

        fault_test(32'd0);
        fault_test(32'd17);

        sel = 1;
        do_reset();
        run_seq(1, 1, 0, 20, 0, 0);
        chk("mul_pass", s_pass, 15);
        chk("mul_fail_state", {s_fail, s_state}, {32'd0, 3'd2});

        sel = 0;
        do_reset();
        run_seq(0, 3, 5, 47, 0, 0);
        chk("abort_pre_pass", s_pass, 40);
        chk("sb_before_abort", sbq.size(), 0);
        reset = 1;
        dut_delay = 32'hFFFF;
        @(negedge clk_dut);
        reset = 0;
        issued = 0;
        chk("abort_idle", {s_state, s_pass, s_fail}, 0);
        run_seq(0, 3, 5, 120, 0, 0);
        chk("recal_pass", {s_pass, s_fail, s_done}, {32'd100, 32'd0, 1'b1});

        chk("sb_final", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
